ajw_32bit_div_unit: RTL and testbench
=====================================

// Module: ajw_32bit_div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
//  Sits in EX beside the single-cycle add/sub unit. It accepts one operation per
//  valid/ready handshake and returns a 32-bit quotient or remainder.
//  Multi-cycle: the pipeline stalls EX while in_ready_o=0 or until out_valid_o is taken.
// PARAMETERS
//  XLEN      32   operand/result width; only 32 is supported
//  CNT_W     6    iteration counter width (holds 0..XLEN)
// PORTS
//  clk_i        in   1     single clock, rising edge
//  rst_i        in   1     synchronous, active-high reset
//  in_valid_i   in   1     operation request
//  in_ready_o   out  1     unit idle; request accepted when in_valid_i & in_ready_o
//  op_i         in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (= funct3[1:0])
//  opX_i        in   32    dividend
//  opY_i        in   32    divisor
//  flush_i      in   1     kill in-flight op (branch mispredict / trap)
//  out_valid_o  out  1     result_o valid; held until out_ready_i
//  out_ready_i  in   1     consumer accepts result
//  result_o     out  32    quotient (DIV/DIVU) or remainder (REM/REMU)
//  dbz_o        out  1     divisor was zero (informational; qualified by out_valid_o)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready_o=1; out_valid_o=0; result_o=0; dbz_o=0; counter=0.
//  FSM IDLE -> CALC -> DONE -> IDLE:
//   IDLE: in_ready_o=1. On accept, latch op. Signed ops: take |opX|, |opY|; record
//     q_neg = X[31]^Y[31] and r_neg = X[31]. opY==0 or (signed & X==32'h8000_0000 &
//     Y==32'hFFFF_FFFF) -> DONE directly (fast path). Otherwise -> CALC, cnt=32.
//   CALC: each cycle, rem = {rem[30:0], dvd[31]}; dvd <<= 1; trial = rem - dvs (33-bit);
//     trial[32]==0 -> rem = trial[31:0], shift in q bit 1; else shift in 0. cnt-1.
//     After the cnt==1 step -> DONE.
//   DONE: out_valid_o=1, result_o stable; apply sign fix (q negated if q_neg; r negated
//     if r_neg). On out_ready_i -> IDLE, and in_ready_o=1 in the next cycle.
//  Latency (accept to out_valid_o): normal 33 cycles; fast path 1 cycle.
//   Throughput: one op per 34 cycles minimum, because DONE->IDLE costs one cycle.
//  Special results (RISC-V spec):
//   div by 0: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> opX; dbz_o=1.
//   overflow DIV -2^31/-1 -> 32'h8000_0000; REM -> 0; dbz_o=0.
//  Remainder sign follows dividend; quotient truncates toward zero.
//  in_valid_i is ignored outside IDLE (no queueing). op and operands are sampled only at accept.
//  flush_i: highest priority after rst_i. In any state -> IDLE next cycle;
//   out_valid_o drops and no result is produced. Flush with in_valid_i in IDLE: not accepted.
//  A flush in DONE coincident with out_ready_i: flush wins, so the result is discarded.
//  rst_i mid-CALC: the next cycle is the full reset state.
//  Arithmetic: 33-bit trial subtract. Negation is ~x+1, computed mod 2^32.
// STRUCTURE
//  ajw_div_pkg: div_op_e enum (DIV/DIVU/REM/REMU), div_state_e (IDLE/CALC/DONE),
//   XLEN and CNT_W constants, and a function for the signed-op predicate.
//  Sub-module ajw_div_step: combinational single restoring step
//   (rem_i, dvd_msb_i, dvs_i -> rem_o, qbit_o). It is instantiated once; the FSM and
//   registers (rem, dvd/quotient, dvs, cnt, flags) live in the top module.
// TESTING
//  1 DIVU 100/7, out_ready_i=1 -> out_valid_o at cycle 33, result 14; REMU -> 2.
//  2 DIV -7/2 -> 32'hFFFF_FFFD (-3); REM -7/2 -> 32'hFFFF_FFFF (-1); REM 7/-2 -> 1.
//  3 DIVU 5/0 -> 32'hFFFF_FFFF, dbz_o=1, latency 1; REM 5/0 -> 5.
//  4 DIV 32'h8000_0000/32'hFFFF_FFFF -> 32'h8000_0000, latency 1; REM -> 0.
//  5 out_ready_i low 10 cycles in DONE -> result_o and out_valid_o stable and in_ready_o=0;
//    release -> in_ready_o=1 next cycle.
//  6 flush_i at CALC cycle 15 -> IDLE next cycle, no out_valid_o. Then DIVU 9/3 -> 3.
//    rst_i mid-CALC -> reset values next cycle.

Source files
------------

// File: rtl/ajw_div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package ajw_div_pkg;

    localparam int unsigned DIV_XLEN  = 32;
    localparam int unsigned DIV_CNT_W = 6;

    // Encoding matches funct3[1:0] of the M-extension divide group.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // DIV and REM treat operands as two's complement.
    function automatic logic op_is_signed(input div_op_e op);
        return ~op[0];
    endfunction

    // REM/REMU return the remainder instead of the quotient.
    function automatic logic op_is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/ajw_32bit_div_unit_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module ajw_div_step
    import ajw_div_pkg::*;
(
    input  logic [DIV_XLEN-1:0] rem_i,
    input  logic                dvd_msb_i,
    input  logic [DIV_XLEN-1:0] dvs_i,
    output logic [DIV_XLEN-1:0] rem_o,
    output logic                qbit_o
);

    logic [DIV_XLEN-1:0] shifted;
    logic [DIV_XLEN:0]   trial;

    // The bit shifted out of rem is kept in the decision: when set, the shifted
    // value is at least 2^32 and therefore always exceeds the divisor, and the
    // low 32 bits of the 33-bit trial are still the correct difference.
    always_comb begin
        shifted = {rem_i[DIV_XLEN-2:0], dvd_msb_i};
        trial   = {1'b0, shifted} - {1'b0, dvs_i};
        qbit_o  = rem_i[DIV_XLEN-1] | ~trial[DIV_XLEN];
        rem_o   = qbit_o ? trial[DIV_XLEN-1:0] : shifted;
    end

endmodule

// File: rtl/ajw_32bit_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
module ajw_32bit_div_unit
    import ajw_div_pkg::*;
#(
    parameter int unsigned XLEN  = DIV_XLEN,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] opX_i,
    input  logic [XLEN-1:0] opY_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            dbz_o
);

    div_state_e      state;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic            is_rem;
    logic            q_neg;
    logic            r_neg;

    div_op_e         in_op;
    logic            in_signed;
    logic            x_neg;
    logic            y_neg;
    logic [XLEN-1:0] abs_x;
    logic [XLEN-1:0] abs_y;
    logic            div_zero;
    logic            overflow;

    logic [XLEN-1:0] step_rem;
    logic            step_qbit;
    logic [XLEN-1:0] final_q;
    logic [XLEN-1:0] fixed_q;
    logic [XLEN-1:0] fixed_r;

    // Operand preparation at accept: magnitudes, signs and fast-path detection.
    always_comb begin
        in_op     = div_op_e'(op_i);
        in_signed = op_is_signed(in_op);
        x_neg     = in_signed & opX_i[XLEN-1];
        y_neg     = in_signed & opY_i[XLEN-1];
        abs_x     = x_neg ? (~opX_i + 1'b1) : opX_i;
        abs_y     = y_neg ? (~opY_i + 1'b1) : opY_i;
        div_zero  = (opY_i == '0);
        overflow  = in_signed & (opX_i == {1'b1, {(XLEN-1){1'b0}}}) & (opY_i == '1);
    end

    ajw_div_step u_step (
        .rem_i     (rem),
        .dvd_msb_i (dvd[XLEN-1]),
        .dvs_i     (dvs),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Sign correction applied to the outcome of the final iteration.
    always_comb begin
        final_q = {dvd[XLEN-2:0], step_qbit};
        fixed_q = q_neg ? (~final_q + 1'b1) : final_q;
        fixed_r = r_neg ? (~step_rem + 1'b1) : step_rem;
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            dbz_o       <= 1'b0;
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            is_rem      <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else if (flush_i) begin
            state       <= ST_IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        is_rem     <= op_is_rem(in_op);
                        q_neg      <= x_neg ^ y_neg;
                        r_neg      <= x_neg;
                        in_ready_o <= 1'b0;
                        if (div_zero) begin
                            state       <= ST_DONE;
                            out_valid_o <= 1'b1;
                            dbz_o       <= 1'b1;
                            result_o    <= op_is_rem(in_op) ? opX_i : '1;
                        end else if (overflow) begin
                            state       <= ST_DONE;
                            out_valid_o <= 1'b1;
                            dbz_o       <= 1'b0;
                            result_o    <= op_is_rem(in_op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        end else begin
                            state <= ST_CALC;
                            rem   <= '0;
                            dvd   <= abs_x;
                            dvs   <= abs_y;
                            cnt   <= CNT_W'(XLEN);
                        end
                    end
                end
                ST_CALC: begin
                    rem <= step_rem;
                    dvd <= {dvd[XLEN-2:0], step_qbit};
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state       <= ST_DONE;
                        out_valid_o <= 1'b1;
                        dbz_o       <= 1'b0;
                        result_o    <= is_rem ? fixed_r : fixed_q;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        state       <= ST_IDLE;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ajw_32bit_div_unit.sv
// Self-checking bench for ajw_32bit_div_unit: vector table, random ops against a
// reference model, and hand-written handshake / flush / reset sequences.
module tb_ajw_32bit_div_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] opx;
    logic [31:0] opy;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        dbz;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    ajw_32bit_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .opX_i       (opx),
        .opY_i       (opy),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .dbz_o       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built on native signed/unsigned integer division.
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sx / sy;
            2'b01:   return x / y;
            2'b10:   return sx % sy;
            default: return x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one op, push its expectation, then pop and compare when the result appears.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ed, input int el);
        exp_t e;
        int   guard;
        int   lat;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        e.res = er;
        e.dbz = ed;
        e.lat = el;
        sb.push_back(e);
        op       = o;
        opx      = x;
        opy      = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
        check("result", result, e.res);
        check("dbz", {31'd0, dbz}, {31'd0, e.dbz});
        check("latency", lat, e.lat);
    endtask

    initial begin
        vec_t vecs[$];
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int          n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 2'b00;
        opx       = '0;
        opy       = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 33});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          1'b0, 33});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 33});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 33});
        vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1});
        vecs.push_back('{2'b10, 32'd5,          32'd0,          32'd5,          1'b1, 1});
        vecs.push_back('{2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1, 1});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 33});
        vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 33});
        vecs.push_back('{2'b11, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 33});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back('{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, 33});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_dbz", {31'd0, dbz}, 32'd0);

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].dbz, vecs[i].lat);

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i % 4 == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            if (i % 3 == 0) rx = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, rx[30:0]};
            do_op(ro, rx, ry, ref_res(ro, rx, ry), (ry == 32'd0), ref_lat(ro, rx, ry));
        end

        // Backpressure: result held stable in DONE, then a one-cycle hop back to IDLE.
        tick();
        out_ready = 1'b0;
        op = 2'b01; opx = 32'd100; opy = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", result, 32'd14);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush in the middle of CALC, with a request presented alongside the flush in IDLE.
        op = 2'b01; opx = 32'd100; opy = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        flush = 1'b1;
        tick();
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        op = 2'b01; opx = 32'd9; opy = 32'd3; in_valid = 1'b1;
        tick();
        check("flush_blocks_accept", {31'd0, in_ready}, 32'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) n++;
            tick();
        end
        check("flush_no_result", n, 0);
        do_op(2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 33);

        // Flush in DONE together with out_ready: result discarded, back to IDLE.
        tick();
        out_ready = 1'b0;
        do_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_done_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-CALC restores every reset value on the following cycle.
        op = 2'b01; opx = 32'd100; opy = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("pre_reset_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_dbz", {31'd0, dbz}, 32'd0);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
